// File: rtl/counter_down_reload_pkg.sv
// Shared definitions for the reloadable down counter: state encoding, mode values, default width.
package counter_down_reload_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_RELOAD  = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/counter_down_reload_reg_load_en.sv
// WIDTH-bit register with synchronous clear (dominant) and load enable.
module counter_down_reload_reg_load_en
    import counter_down_reload_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/counter_down_reload.sv
// Presettable down counter with auto-reload / one-shot modes and a one-cycle borrow pulse.
module counter_down_reload
    import counter_down_reload_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] Din,
    input  logic             En,
    input  logic             Mode,
    output logic [WIDTH-1:0] count,
    output logic             Borrow,
    output logic             Busy
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic             r_borrow;
    logic [WIDTH-1:0] w_reload;
    logic             w_step;
    logic             w_at_one;
    logic             w_at_zero;

    counter_down_reload_reg_load_en #(
        .WIDTH (WIDTH)
    ) u_reload_reg (
        .i_clk  (Clk),
        .i_clr  (Clr),
        .i_load (Load),
        .i_d    (Din),
        .o_q    (w_reload)
    );

    assign w_step    = (r_state == ST_RUN) && En && !Load;
    assign w_at_one  = (r_count == WIDTH'(1));
    assign w_at_zero = (r_count == '0);

    // State register
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; Load wins over counting, illegal encoding recovers to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (Load) begin
            w_state_nxt = (Din != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_RUN: begin
                    if (En && w_at_zero && (Mode == MODE_ONESHOT)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode from the state register
    always_comb begin
        Busy = 1'b0;
        if (r_state == ST_RUN) begin
            Busy = 1'b1;
        end
    end

    // Count datapath and borrow; borrow clears on any edge that is not the 1->0 step
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_count  <= '0;
            r_borrow <= 1'b0;
        end else if (Load) begin
            r_count  <= Din;
            r_borrow <= 1'b0;
        end else begin
            r_borrow <= w_step && w_at_one;
            if (w_step) begin
                if (w_at_zero) begin
                    if (Mode == MODE_RELOAD) begin
                        r_count <= w_reload;
                    end
                end else begin
                    r_count <= r_count - WIDTH'(1);
                end
            end
        end
    end

    assign count  = r_count;
    assign Borrow = r_borrow;

endmodule
